// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and digit constants for the door lock sequencer
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    FAIL,
    LOCKOUT,
    SETPW
  } lock_state_t;

  localparam logic [3:0]  BLANK_DIGIT  = 4'hF;
  localparam int          NUM_DIGITS   = 4;
  localparam logic [15:0] BLANK_DIGITS = {NUM_DIGITS{BLANK_DIGIT}};

  function automatic logic digit_ok(input logic [3:0] v);
    return v <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - shared 32-bit down-counter for all timed lock states
module lock_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 32'd1;
    end
  end

  // Flags the last cycle of a window, so a state loaded with N lasts exactly N cycles.
  assign expired = (count == 32'd1);

endmodule

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - door lock sequencer: code entry, compare, unlock/err/lockout, set-password grant
module lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [31:0] UNLOCK_CYC   = 32'd50_000_000,
  parameter logic [31:0] ERR_CYC      = 32'd25_000_000,
  parameter logic [31:0] LOCKOUT_CYC  = 32'd500_000_000,
  parameter logic [31:0] ENTRY_TO_CYC = 32'd250_000_000,
  parameter logic [31:0] SET_TO_CYC   = 32'd1_500_000_000,
  parameter int unsigned MAX_FAIL     = 3
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        key_valid,
  input  logic        key_long,
  input  logic [3:0]  value_4bit,
  input  logic [15:0] password,
  input  logic        pass_busy,
  output logic        enb_set,
  output logic        unlock,
  output logic        err,
  output logic        alarm,
  output logic        set_done,
  output logic [15:0] digits,
  output logic [2:0]  fail_cnt
);

  localparam logic [2:0] MAX_FAIL_3 = 3'(MAX_FAIL);

  lock_state_t state, next_state;
  logic [2:0]  cnt, cnt_next;
  logic [15:0] digits_next;
  logic [2:0]  fail_next;
  logic [2:0]  fail_inc;
  logic        seen_busy, seen_next;
  logic        busy_d;
  logic        set_done_next;
  logic        accept;
  logic        load;
  logic [31:0] load_val;
  logic        expired;

  // key_long takes priority, so a simultaneous key_valid is dropped.
  assign accept   = key_valid && !key_long && digit_ok(value_4bit);
  assign fail_inc = fail_cnt + 3'd1;

  lock_timer u_timer (
    .clk      (clk_in),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_comb begin
    next_state    = state;
    cnt_next      = cnt;
    digits_next   = digits;
    fail_next     = fail_cnt;
    seen_next     = seen_busy;
    set_done_next = 1'b0;
    load          = 1'b0;
    load_val      = '0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          digits_next = {value_4bit, digits[15:4]};
          cnt_next    = 3'd1;
          next_state  = ENTRY;
        end
      end
      ENTRY: begin
        if (key_long) begin
          next_state = IDLE;
        end else if (accept) begin
          digits_next = {value_4bit, digits[15:4]};
          cnt_next    = cnt + 3'd1;
          load        = 1'b1;
          if (cnt_next == 3'(NUM_DIGITS)) next_state = CHECK;
        end else if (expired) begin
          next_state = IDLE;
        end
      end
      CHECK: begin
        if (digits == password) begin
          fail_next  = '0;
          next_state = OPEN;
        end else begin
          fail_next  = fail_inc;
          next_state = (fail_inc == MAX_FAIL_3) ? LOCKOUT : FAIL;
        end
      end
      OPEN: begin
        if (key_long)     next_state = SETPW;
        else if (expired) next_state = IDLE;
      end
      FAIL: begin
        if (expired) next_state = IDLE;
      end
      LOCKOUT: begin
        if (expired) begin
          fail_next  = '0;
          next_state = IDLE;
        end
      end
      SETPW: begin
        if (pass_busy) seen_next = 1'b1;
        // Commit is the busy falling edge, but only once the block has actually started.
        if (busy_d && !pass_busy && seen_busy) begin
          set_done_next = 1'b1;
          next_state    = IDLE;
        end else if (expired) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    if (next_state != state) begin
      load      = 1'b1;
      seen_next = 1'b0;
    end
    if (next_state == IDLE) digits_next = BLANK_DIGITS;

    case (next_state)
      ENTRY:   load_val = ENTRY_TO_CYC;
      OPEN:    load_val = UNLOCK_CYC;
      FAIL:    load_val = ERR_CYC;
      LOCKOUT: load_val = LOCKOUT_CYC;
      SETPW:   load_val = SET_TO_CYC;
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      digits    <= BLANK_DIGITS;
      fail_cnt  <= '0;
      seen_busy <= 1'b0;
      busy_d    <= 1'b0;
      unlock    <= 1'b0;
      err       <= 1'b0;
      alarm     <= 1'b0;
      enb_set   <= 1'b0;
      set_done  <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      digits    <= digits_next;
      fail_cnt  <= fail_next;
      seen_busy <= seen_next;
      busy_d    <= pass_busy;
      unlock    <= (next_state == OPEN);
      err       <= (next_state == FAIL);
      alarm     <= (next_state == LOCKOUT);
      enb_set   <= (next_state == SETPW);
      set_done  <= set_done_next;
    end
  end

endmodule
